// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the
// valid/ready fetch-to-decode channel. The fetch unit is the master.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();
    localparam int unsigned DATA_W = 32;

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational
// instruction memory, and buffers {pc, instr} in a 2-entry skid FIFO
// toward decode. Handles start, halt and branch/jump redirect.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to trap fetches at
// pc >= IMEM_WORDS*4 into a sticky FAULT state; without it addresses
// alias through pc[7:2] and o_fetch_fault is tied low.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       IMEM_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_halt_req,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_halted,
    output logic               o_fetch_fault,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned       DATA_W        = 32;
    localparam int unsigned       CNT_W         = 2;
    localparam logic [CNT_W-1:0]  LP_FIFO_FULL  = CNT_W'(2);
    localparam logic [ADDR_W-1:0] LP_PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LP_ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LP_IMEM_BYTES = ADDR_W'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic [ADDR_W-1:0] r_head_pc;
    logic [DATA_W-1:0] r_head_instr;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [DATA_W-1:0] r_skid_instr;
    logic              r_halted;

    logic              w_redirect;
    logic              w_pop;
    logic              w_oob;
    logic              w_fetch;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic [CNT_W-1:0]  w_count_nxt;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic              r_fault;

    // Fetch address beyond the populated memory traps the sequencer
    assign w_oob = (r_pc >= LP_IMEM_BYTES);
`else
    logic              w_unused_bounds;

    // Without the check every address aliases into the memory
    assign w_oob = 1'b0;
    // Bounds constant has no consumer when the check is compiled out
    assign w_unused_bounds = ^LP_IMEM_BYTES;
`endif

    // Per-cycle fetch decisions: redirect flush, pop, push and new occupancy
    always_comb begin
        w_redirect        = 1'b0;
        w_pop             = 1'b0;
        w_fetch           = 1'b0;
        w_push            = 1'b0;
        w_count_after_pop = r_count;
        w_count_nxt       = r_count;

        w_redirect = i_redirect_valid && ((r_state == ST_RUN) || (r_state == ST_HALT));
        w_pop      = r_valid && bus.if_ready;
        // halt_req wins over fetching in the same cycle; redirect suppresses the push
        w_fetch    = (r_state == ST_RUN) && !w_redirect && !i_halt_req && !w_oob;
        // A full FIFO still accepts a push when the head leaves this cycle
        w_push     = w_fetch && ((r_count != LP_FIFO_FULL) || w_pop);

        w_count_after_pop = r_count - CNT_W'(w_pop);
        if (w_redirect) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = w_count_after_pop + CNT_W'(w_push);
        end
    end

    // Control FSM with registered halted/fault status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_halted <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
            r_fault  <= 1'b0;
`endif
        end else begin
            r_halted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= (w_count_nxt == '0);
                    end
`ifdef FETCH_BOUNDS_CHECK_EN
                    else if (w_oob && !w_redirect) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end
`endif
                end
                ST_HALT: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_halted <= (w_count_nxt == '0);
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // PC sequencing and the 2-entry skid FIFO (head entry drives decode)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC & LP_ALIGN_MASK;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_head_pc    <= '0;
            r_head_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);

            if (w_redirect) begin
                r_pc <= i_redirect_pc & LP_ALIGN_MASK;
            end else if (w_push) begin
                r_pc <= r_pc + LP_PC_STEP;
            end

            // On a flush the head keeps the last presented entry
            if (!w_redirect) begin
                if (w_pop && (r_count == LP_FIFO_FULL)) begin
                    r_head_pc    <= r_skid_pc;
                    r_head_instr <= r_skid_instr;
                end
                if (w_push) begin
                    if (w_count_after_pop == '0) begin
                        r_head_pc    <= r_pc;
                        r_head_instr <= bus.imem_rdata;
                    end else begin
                        r_skid_pc    <= r_pc;
                        r_skid_instr <= bus.imem_rdata;
                    end
                end
            end
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = r_valid;
    assign bus.if_pc     = r_head_pc;
    assign bus.if_instr  = r_head_instr;
    assign o_halted      = r_halted;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign o_fetch_fault = r_fault;
`else
    assign o_fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a queue-based reference model
// predicts per-cycle status and every accepted handshake; a separate
// monitor pops and compares. Directed scenarios then randomized traffic.
module tb_instr_fetch_unit;
    localparam int unsigned ADDR_W     = 32;
    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int unsigned IMEM_WORDS = 64;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef enum int {M_IDLE, M_RUN, M_HALT, M_FAULT} mstate_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic        halted;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } status_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        halted;
    logic        fetch_fault;
    logic [31:0] mem [IMEM_WORDS];

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    mstate_t  m_state;
    logic [31:0] m_pc;
    logic     m_fault;
    entry_t   m_last;
    entry_t   m_fifo[$];
    status_t  status_q[$];
    entry_t   txn_q[$];

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.imem_rdata = mem[bus.imem_addr[7:2]];
    assign bus.if_ready   = ready;

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (start),
        .i_halt_req      (halt_req),
        .i_redirect_valid(redirect_valid),
        .i_redirect_pc   (redirect_pc),
        .o_halted        (halted),
        .o_fetch_fault   (fetch_fault),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at each falling edge publish the expected outputs of
    // the current cycle, then advance to the state after the next rising edge
    always @(negedge clk) begin
        status_t s;
        entry_t  e;
        logic    redir, pop, oob, fetch, room;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_pc    = RESET_PC;
            m_fault = 1'b0;
            m_last  = '0;
            m_fifo.delete();
        end
        s.valid = (m_fifo.size() != 0);
        if (s.valid) m_last = m_fifo[0];
        s.addr   = m_pc;
        s.halted = (m_state == M_HALT) && (m_fifo.size() == 0);
        s.fault  = m_fault;
        s.pc     = m_last.pc;
        s.instr  = m_last.instr;
        status_q.push_back(s);

        if (rst_n) begin
            redir = redirect_valid && (m_state == M_RUN || m_state == M_HALT);
            pop   = s.valid && ready;
            oob   = BOUNDS && (m_pc >= 32'(IMEM_WORDS * 4));
            fetch = (m_state == M_RUN) && !redir && !halt_req && !oob;
            room  = (m_fifo.size() < 2) || pop;
            if (pop) txn_q.push_back(m_fifo[0]);
            if (redir) begin
                m_fifo.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(m_fifo.pop_front());
                if (fetch && room) begin
                    e.pc    = m_pc;
                    e.instr = mem[m_pc[7:2]];
                    m_fifo.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            case (m_state)
                M_IDLE: if (start) m_state = M_RUN;
                M_RUN: begin
                    if (halt_req) m_state = M_HALT;
                    else if (oob && !redir) begin
                        m_state = M_FAULT;
                        m_fault = 1'b1;
                    end
                end
                M_HALT: if (start) m_state = M_RUN;
                default: ;
            endcase
        end
    end

    // Monitor: per-cycle status compare plus handshake scoreboard
    always @(negedge clk) begin
        status_t s;
        entry_t  e;
        #1;
        if (status_q.size() == 0) begin
            check("status_queue_empty", 64'd1, 64'd0);
        end else begin
            s = status_q.pop_front();
            check("if_valid", 64'(bus.if_valid), 64'(s.valid));
            check("imem_addr", 64'(bus.imem_addr), 64'(s.addr));
            check("halted", 64'(halted), 64'(s.halted));
            check("fetch_fault", 64'(fetch_fault), 64'(s.fault));
            check("if_pc", 64'(bus.if_pc), 64'(s.pc));
            check("if_instr", 64'(bus.if_instr), 64'(s.instr));
        end
        if (bus.if_valid && ready) begin
            if (txn_q.size() == 0) begin
                check("txn_unexpected", 64'(bus.if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = txn_q.pop_front();
                check("txn_pc", 64'(bus.if_pc), 64'(e.pc));
                check("txn_instr", 64'(bus.if_instr), 64'(e.instr));
                n_txn++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start          = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        check("rst_if_valid", 64'(bus.if_valid), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        check("rst_if_pc", 64'(bus.if_pc), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        idle_inputs();
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;

        // Streaming from reset with decode always ready
        do_reset();
        ready = 1'b1;
        pulse_start();
        repeat (7) cyc();

        // Backpressure: two entries held, PC parks at 8
        do_reset();
        pulse_start();
        repeat (4) cyc();
        check("stall_imem_addr", 64'(bus.imem_addr), 64'h8);
        check("stall_if_pc", 64'(bus.if_pc), 64'h0);
        check("stall_if_valid", 64'(bus.if_valid), 64'd1);
        ready = 1'b1;
        repeat (5) cyc();

        // Redirect with FIFO holding pc 4,8 flushes and realigns the target
        do_reset();
        pulse_start();
        cyc();
        cyc();
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        check("pre_redir_if_pc", 64'(bus.if_pc), 64'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        cyc();
        redirect_valid = 1'b0;
        check("redir_if_valid", 64'(bus.if_valid), 64'd0);
        check("redir_imem_addr", 64'(bus.imem_addr), 64'h10);
        ready = 1'b1;
        repeat (4) cyc();

        // Halt with two entries queued drains, then resumes sequentially
        do_reset();
        pulse_start();
        cyc();
        cyc();
        halt_req = 1'b1;
        ready    = 1'b1;
        cyc();
        halt_req = 1'b0;
        cyc();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_imem_addr", 64'(bus.imem_addr), 64'h8);
        repeat (2) cyc();
        pulse_start();
        repeat (4) cyc();

        // Asynchronous reset between edges clears immediately
        do_reset();
        ready = 1'b1;
        pulse_start();
        repeat (4) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_if_valid", 64'(bus.if_valid), 64'd0);
        check("async_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) cyc();
        check("post_rst_idle_valid", 64'(bus.if_valid), 64'd0);
        check("post_rst_idle_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        pulse_start();
        repeat (3) cyc();

        // Redirect past the end of memory
        do_reset();
        ready = 1'b1;
        pulse_start();
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        cyc();
`ifdef FETCH_BOUNDS_CHECK_EN
        check("oob_fault", 64'(fetch_fault), 64'd1);
        pulse_start();
        repeat (3) cyc();
        check("oob_no_valid", 64'(bus.if_valid), 64'd0);
        check("oob_fault_sticky", 64'(fetch_fault), 64'd1);
`else
        check("alias_fault", 64'(fetch_fault), 64'd0);
        check("alias_if_pc", 64'(bus.if_pc), 64'h100);
        check("alias_if_instr", 64'(bus.if_instr), 64'(mem[0]));
        repeat (3) cyc();
`endif

        // Randomized traffic with occasional mid-cycle resets
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                idle_inputs();
                #2;
                rst_n = 1'b0;
                @(posedge clk);
                #3;
                rst_n = 1'b1;
                cyc();
            end else begin
                ready          = ($urandom_range(0, 3) != 0);
                start          = ($urandom_range(0, 9) == 0);
                halt_req       = ($urandom_range(0, 19) == 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else redirect_pc = 32'($urandom_range(0, 'h13F));
                cyc();
            end
        end
        idle_inputs();
        ready = 1'b1;
        repeat (4) cyc();

        check("txn_leftover", 64'(txn_q.size()), 64'd0);
        check("handshakes_seen", 64'(n_txn >= 200), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
